sweep_scheduler: RTL and testbench

Sequences the frequency datapath during sweep operation: takes the operator's base frequency, sweep range, sweep speed and sweep mode, and advances an instantaneous frequency once per millisecond. Each new frequency is handed to the waveform generator over a valid/ready handshake. Sits between the input processor (configuration source) and the phase-accumulator/DDS core (consumer). With sweep off, it forwards the base frequency unchanged.

---
 rtl/sweep_scheduler.sv | 165 ++++++++++++++++
 tb/tb_sweep_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_scheduler.sv
// Purpose: steps an instantaneous frequency through static/sawtooth/triangle/single-shot sweeps and offers it to the DDS.
// Latency: a restart or sweep step reaches freq_out one cycle after cur_freq changes.
// Backpressure: freq_out is held while freq_valid && !freq_ready; newer values coalesce, latest wins.
module sweep_scheduler #(
    parameter int TICK_CYCLES = 100000,
    parameter int FREQ_MAX    = 999999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  sweep_mode,
    input  logic [19:0] base_freq,
    input  logic [16:0] sweep_range,
    input  logic [12:0] sweep_speed,
    input  logic        restart,
    output logic [19:0] freq_out,
    output logic        freq_valid,
    input  logic        freq_ready,
    output logic        sweep_dir,
    output logic        sweep_done
);

    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [20:0]   FMAX      = 21'(FREQ_MAX);

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_UP     = 2'd1,
        ST_DOWN   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [19:0]   cur_freq, cur_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          dirty, dirty_n;
    logic          saw_wrap, saw_wrap_n;
    logic          dir_n, done_n;
    logic [1:0]    mode_q;
    logic [19:0]   base_q;
    logic [16:0]   range_q;

    logic          restart_evt;
    logic          tick;
    logic          load;
    logic [20:0]   top_sum, top, step_up, down_thr;

    assign restart_evt = restart || (sweep_mode != mode_q) ||
                         (base_freq != base_q) || (sweep_range != range_q);

    // All comparisons at 21 bits so a sum past 2^20 can never alias below top.
    assign top_sum  = {1'b0, base_freq} + {4'b0, sweep_range};
    assign top      = (top_sum > FMAX) ? FMAX : top_sum;
    assign step_up  = {1'b0, cur_freq} + {8'b0, sweep_speed};
    assign down_thr = {1'b0, base_freq} + {8'b0, sweep_speed};

    assign tick = ((state == ST_UP) || (state == ST_DOWN)) && (cnt == TICK_LAST);
    assign load = dirty && (!freq_valid || freq_ready);

    always_comb begin
        state_n    = state;
        cur_n      = cur_freq;
        cnt_n      = cnt;
        saw_wrap_n = saw_wrap;
        dir_n      = sweep_dir;
        done_n     = sweep_done;

        if (restart_evt) begin
            cur_n      = base_freq;
            cnt_n      = '0;
            saw_wrap_n = 1'b0;
            dir_n      = 1'b0;
            done_n     = 1'b0;
            state_n    = (sweep_mode == MODE_STATIC) ? ST_STATIC : ST_UP;
        end else begin
            case (state)
                ST_STATIC: begin
                    cur_n = base_freq;
                end
                ST_UP: begin
                    cnt_n = tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        if (saw_wrap) begin
                            cur_n      = base_freq;
                            saw_wrap_n = 1'b0;
                        end else if (step_up < top) begin
                            cur_n = step_up[19:0];
                        end else begin
                            cur_n = top[19:0];
                            if (sweep_mode == MODE_SAW) begin
                                saw_wrap_n = 1'b1;
                            end else if (sweep_mode == MODE_TRI) begin
                                state_n = ST_DOWN;
                                dir_n   = 1'b1;
                            end else begin
                                state_n = ST_HOLD;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                ST_DOWN: begin
                    cnt_n = tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        if ({1'b0, cur_freq} > down_thr) begin
                            cur_n = cur_freq - {7'b0, sweep_speed};
                        end else begin
                            cur_n   = base_freq;
                            state_n = ST_UP;
                            dir_n   = 1'b0;
                        end
                    end
                end
                default: begin
                    cnt_n = '0;
                end
            endcase
        end

        dirty_n = (cur_n != cur_freq) || (dirty && !load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_STATIC;
            cur_freq   <= '0;
            cnt        <= '0;
            dirty      <= 1'b0;
            saw_wrap   <= 1'b0;
            sweep_dir  <= 1'b0;
            sweep_done <= 1'b0;
            mode_q     <= '0;
            base_q     <= '0;
            range_q    <= '0;
        end else begin
            state      <= state_n;
            cur_freq   <= cur_n;
            cnt        <= cnt_n;
            dirty      <= dirty_n;
            saw_wrap   <= saw_wrap_n;
            sweep_dir  <= dir_n;
            sweep_done <= done_n;
            mode_q     <= sweep_mode;
            base_q     <= base_freq;
            range_q    <= sweep_range;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_out   <= '0;
            freq_valid <= 1'b0;
        end else if (load) begin
            freq_out   <= cur_freq;
            freq_valid <= 1'b1;
        end else if (freq_valid && freq_ready) begin
            freq_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sweep_scheduler.sv
// Directed bench for sweep_scheduler: expected transfers are queued by the stimulus,
// and a negedge monitor pops and checks value, step spacing, sweep_dir and sweep_done.
module tb_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sweep_mode;
    logic [19:0] base_freq;
    logic [16:0] sweep_range;
    logic [12:0] sweep_speed;
    logic        restart;
    logic [19:0] freq_out;
    logic        freq_valid;
    logic        freq_ready;
    logic        sweep_dir;
    logic        sweep_done;

    sweep_scheduler #(.TICK_CYCLES(10), .FREQ_MAX(999999)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sweep_mode  (sweep_mode),
        .base_freq   (base_freq),
        .sweep_range (sweep_range),
        .sweep_speed (sweep_speed),
        .restart     (restart),
        .freq_out    (freq_out),
        .freq_valid  (freq_valid),
        .freq_ready  (freq_ready),
        .sweep_dir   (sweep_dir),
        .sweep_done  (sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] freq;
        int          gap;   // cycles since previous transfer, 0 = don't care
        logic        dir;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_xfer = 0;
    logic        stalled_prev = 1'b0;
    logic [19:0] held_out = '0;

    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (stalled_prev && freq_valid) begin
            tests++;
            if (freq_out !== held_out) begin
                fails++;
                $display("FAIL stall_stable: freq_out=%0d while stalled, required %0d", freq_out, held_out);
            end
        end
        if (freq_valid && freq_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_xfer: freq_out=%0d dir=%0b done=%0b, none required", freq_out, sweep_dir, sweep_done);
            end else begin
                e = sb.pop_front();
                if (freq_out !== e.freq || sweep_dir !== e.dir || sweep_done !== e.done ||
                    (e.gap != 0 && (cyc - last_xfer) != e.gap)) begin
                    fails++;
                    $display("FAIL xfer: freq=%0d dir=%0b done=%0b gap=%0d, required freq=%0d dir=%0b done=%0b gap=%0d",
                             freq_out, sweep_dir, sweep_done, cyc - last_xfer, e.freq, e.dir, e.done, e.gap);
                end
            end
            last_xfer = cyc;
        end
        stalled_prev = freq_valid && !freq_ready;
        held_out     = freq_out;
    end

    task automatic push(input logic [19:0] f, input int gap, input logic dir, input logic done);
        exp_t e;
        e.freq = f; e.gap = gap; e.dir = dir; e.done = done;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            step(1);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d transfers outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic config_sweep(input logic [1:0] m, input logic [19:0] b,
                                input logic [16:0] r, input logic [12:0] s);
        sweep_mode = m; base_freq = b; sweep_range = r; sweep_speed = s;
    endtask

    initial begin
        rst_n = 1'b0; restart = 1'b0; freq_ready = 1'b1;
        config_sweep(2'b00, 20'd100000, 17'd0, 13'd0);
        #12;
        check1("rst_freq_out", 32'(freq_out), 0);
        check1("rst_valid", 32'(freq_valid), 0);
        check1("rst_dir_done", {30'b0, sweep_dir, sweep_done}, 0);

        // Static: one transfer of base, then one more after a base change.
        push(20'd100000, 0, 1'b0, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        step(1);
        check1("release_edge1_valid", 32'(freq_valid), 0);
        step(1);
        check1("release_edge2_valid", 32'(freq_valid), 1);
        check1("release_edge2_out", 32'(freq_out), 100000);
        drain("static", 20);
        step(10);
        check1("static_single_pulse", 32'(freq_valid), 0);
        push(20'd250000, 0, 1'b0, 1'b0);
        base_freq = 20'd250000;
        step(2);
        check1("static_change_valid", 32'(freq_valid), 1);
        drain("static2", 20);
        step(10);

        // Sawtooth: top held one tick, then wraps to base.
        push(20'd100000, 0, 1'b0, 1'b0);
        push(20'd101000, 10, 1'b0, 1'b0);
        push(20'd102000, 10, 1'b0, 1'b0);
        push(20'd103000, 10, 1'b0, 1'b0);
        push(20'd100000, 10, 1'b0, 1'b0);
        push(20'd101000, 10, 1'b0, 1'b0);
        config_sweep(2'b01, 20'd100000, 17'd3000, 13'd1000);
        drain("saw", 100);

        // Triangle with top clamped at FREQ_MAX.
        push(20'd998000, 0, 1'b0, 1'b0);
        push(20'd999500, 10, 1'b0, 1'b0);
        push(20'd999999, 10, 1'b1, 1'b0);
        push(20'd998499, 10, 1'b1, 1'b0);
        push(20'd998000, 10, 1'b0, 1'b0);
        push(20'd999500, 10, 1'b0, 1'b0);
        config_sweep(2'b10, 20'd998000, 17'd5000, 13'd1500);
        drain("tri", 100);

        // Single-shot: completes and holds until a restart pulse.
        push(20'd10000, 0, 1'b0, 1'b0);
        push(20'd11000, 10, 1'b0, 1'b0);
        push(20'd12000, 10, 1'b0, 1'b1);
        config_sweep(2'b11, 20'd10000, 17'd2000, 13'd1000);
        drain("single", 60);
        step(30);
        check1("single_hold_done", 32'(sweep_done), 1);
        check1("single_hold_valid", 32'(freq_valid), 0);
        push(20'd10000, 0, 1'b0, 1'b0);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check1("restart_done_clear", 32'(sweep_done), 0);
        drain("single_restart", 10);

        // Backpressure: 101000 stays offered; 102000 is coalesced away.
        push(20'd100000, 0, 1'b0, 1'b0);
        config_sweep(2'b01, 20'd100000, 17'd3000, 13'd1000);
        drain("bp_start", 10);
        freq_ready = 1'b0;
        step(35);
        check1("bp_stalled_out", 32'(freq_out), 101000);
        check1("bp_stalled_valid", 32'(freq_valid), 1);
        push(20'd101000, 0, 1'b0, 1'b0);
        push(20'd103000, 1, 1'b0, 1'b0);
        push(20'd100000, 3, 1'b0, 1'b0);
        freq_ready = 1'b1;
        drain("bp_release", 20);

        // Asynchronous reset in the middle of a triangle down leg.
        push(20'd998000, 0, 1'b0, 1'b0);
        push(20'd999500, 10, 1'b0, 1'b0);
        push(20'd999999, 10, 1'b1, 1'b0);
        config_sweep(2'b10, 20'd998000, 17'd5000, 13'd1500);
        drain("tri2", 60);
        step(3);
        check1("tri_dir_before_rst", 32'(sweep_dir), 1);
        rst_n = 1'b0;
        #1;
        check1("async_rst_out", 32'(freq_out), 0);
        check1("async_rst_flags", {29'b0, freq_valid, sweep_dir, sweep_done}, 0);
        step(2);
        push(20'd998000, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1);
        check1("rerelease_edge1_valid", 32'(freq_valid), 0);
        step(1);
        check1("rerelease_edge2_out", {11'b0, freq_valid, freq_out}, {11'b0, 1'b1, 20'd998000});
        drain("rerelease", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
